gray_to_binary_dec: RTL and testbench
=====================================

// Module: gray_to_binary_dec
// PURPOSE
//  Receive-side decoder for the binary_to_gray encoding: accepts WIDTH-bit Gray words and returns binary.
//  Bit index 0 is the MSB on both buses; conversion is b[0]=g[0], b[i]=b[i-1]^g[i].
//  One registered stage with valid/ready handshake on both sides.
//  A step monitor checks that consecutive accepted words differ by 0 or +/-1 (mod 2^WIDTH).
//  Sits after Gray-coded counters and pointers; reports direction and counts errors.
// PARAMETERS
//  WIDTH    3  Gray/binary word width; legal range is 2..16.
//  ERR_W    8  Width of the saturating step-error counter.
// PORTS
//  clk_in        in   1        Single clock; rising edge.
//  rst_n_in      in   1        Asynchronous reset, active-low.
//  g_valid_in    in   1        Input word valid.
//  g_ready_out   out  1        Block can accept the input word.
//  g_in          in   WIDTH    Gray word; [0] is the MSB.
//  b_valid_out   out  1        Output word valid.
//  b_ready_in    in   1        Downstream accepts the output word.
//  b_out         out  WIDTH    Binary word; [0] is the MSB.
//  dir_out       out  1        1 = last step +1 (up), 0 = last step -1 (down).
//  step_err_out  out  1        Current output word violated the step rule.
//  err_cnt_out   out  ERR_W    Saturating count of step errors since reset.
// BEHAVIOUR
//  Reset (async assert, release sync to clk_in):
//   - b_valid_out=0, b_out=0, dir_out=1, step_err_out=0, err_cnt_out=0.
//   - Monitor state returns to NO_HIST.
//  Handshake:
//   - g_ready_out = !b_valid_out | b_ready_in (combinational).
//   - Input accept = g_valid_in & g_ready_out.
//   - Output transfer = b_valid_out & b_ready_in.
//   - On accept, at the next edge: b_out <= decode(g_in), b_valid_out <= 1. Latency is 1 cycle.
//   - On transfer with no accept: b_valid_out <= 0.
//   - While b_valid_out=1 and b_ready_in=0: b_out, dir_out and step_err_out hold stable.
//   - Accept and transfer in the same cycle: full throughput, 1 word per cycle.
//  Monitor FSM (advances on accept only):
//   - NO_HIST: first word is never an error; store it as prev; dir_out=1; go to TRACK.
//   - TRACK: d = (new - prev) mod 2^WIDTH.
//     - d=0: repeat; no error; dir_out holds.
//     - d=1: dir_out<=1. This includes wrap 2^WIDTH-1 -> 0.
//     - d=2^WIDTH-1: dir_out<=0. This includes wrap 0 -> 2^WIDTH-1.
//     - Any other d: step_err_out<=1 with that word, err_cnt_out+1 (saturating at all-ones), dir_out holds.
//     - In every case prev<=new, so a bad step resynchronises the monitor.
//   - step_err_out is qualified with b_valid_out and is valid only for the word it accompanies.
//  Reset mid-operation: any pending output is dropped and the next accepted word is treated as first.
//  No combinational path from g_in to b_out; g_ready_out depends only on b_valid_out and b_ready_in.
// TESTING
//  (Words below are written [0]..[WIDTH-1], MSB first, WIDTH=3.)
//  1. Exhaustive decode: feed all 8 Gray words with b_ready_in=1.
//     -> e.g. g 010 -> b 011, g 110 -> b 100, g 100 -> b 111; each appears 1 cycle after accept.
//  2. Count up through wrap: Gray for 6,7,0,1.
//     -> b 110,111,000,001; dir_out=1 throughout; step_err_out=0; err_cnt_out=0.
//  3. Count down 1,0,7.
//     -> dir_out=0 from the second word; no errors.
//     Then feed a jump 7 -> 4 (g 110) -> step_err_out=1, err_cnt_out=1.
//     Then feed 5 -> no error, dir_out=1.
//  4. Backpressure: b_ready_in=0 for 4 cycles with b_valid_out=1.
//     -> g_ready_out=0; b_out is stable; no word is lost or duplicated after release.
//     Also check back-to-back throughput of 1 word/cycle.
//  5. Assert rst_n_in mid-stream with b_valid_out=1.
//     -> all outputs go to reset values immediately.
//     -> the first word after release (e.g. 5 after prior 1) gives no error.
//  6. Feed 300 alternating 0/4 words (ERR_W=8).
//     -> err_cnt_out saturates at 255 and does not wrap.

Source files
------------

// File: rtl/gray_to_binary_dec.sv
// Registered Gray-to-binary decoder with valid/ready handshake on both sides and a
// step monitor that reports count direction and counts illegal jumps between words.
module gray_to_binary_dec #(
   parameter int WIDTH = 3,
   parameter int ERR_W = 8
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             g_valid_in,
   output logic             g_ready_out,
   input  logic [0:WIDTH-1] g_in,
   output logic             b_valid_out,
   input  logic             b_ready_in,
   output logic [0:WIDTH-1] b_out,
   output logic             dir_out,
   output logic             step_err_out,
   output logic [ERR_W-1:0] err_cnt_out
);

   localparam logic [0:0]       S_NO_HIST = 1'b0;
   localparam logic [0:0]       S_TRACK   = 1'b1;
   localparam logic [0:WIDTH-1] STEP_UP   = WIDTH'(1);
   localparam logic [0:WIDTH-1] STEP_DN   = '1;

   logic [0:0]       r_state;
   logic [0:WIDTH-1] r_prev;
   logic [0:WIDTH-1] r_b;
   logic             r_b_valid;
   logic             r_dir;
   logic             r_step_err;
   logic [ERR_W-1:0] r_err_cnt;

   logic [0:WIDTH-1] w_bin;
   logic [0:WIDTH-1] w_diff;
   logic             w_step_ok;
   logic             w_accept;
   logic             w_transfer;

   // Each binary bit is the XOR of all Gray bits from the MSB down to it.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_dec
         assign w_bin[gi] = ^g_in[0:gi];
      end
   endgenerate

   assign w_diff     = w_bin - r_prev;
   assign w_step_ok  = (w_diff == '0) || (w_diff == STEP_UP) || (w_diff == STEP_DN);
   assign g_ready_out = !r_b_valid || b_ready_in;
   assign w_accept   = g_valid_in && g_ready_out;
   assign w_transfer = r_b_valid && b_ready_in;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state    <= S_NO_HIST;
         r_prev     <= '0;
         r_b        <= '0;
         r_b_valid  <= 1'b0;
         r_dir      <= 1'b1;
         r_step_err <= 1'b0;
         r_err_cnt  <= '0;
      end else if (w_accept) begin
         r_b       <= w_bin;
         r_b_valid <= 1'b1;
         r_prev    <= w_bin;
         r_state   <= S_TRACK;
         if (r_state == S_NO_HIST) begin
            r_dir      <= 1'b1;
            r_step_err <= 1'b0;
         end else begin
            // A bad step still updates prev so the monitor resynchronises.
            r_step_err <= !w_step_ok;
            if (w_diff == STEP_UP) begin
               r_dir <= 1'b1;
            end else if (w_diff == STEP_DN) begin
               r_dir <= 1'b0;
            end
            if (!w_step_ok && (r_err_cnt != '1)) begin
               r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
         end
      end else if (w_transfer) begin
         r_b_valid <= 1'b0;
      end
   end

   assign b_out        = r_b;
   assign b_valid_out  = r_b_valid;
   assign dir_out      = r_dir;
   assign step_err_out = r_step_err && r_b_valid;
   assign err_cnt_out  = r_err_cnt;

endmodule

// File: tb/tb_gray_to_binary_dec.sv
// Bench for gray_to_binary_dec (WIDTH=3): decode table, directed monitor sequences,
// backpressure, async reset, counter saturation and a randomized model comparison.
module tb_gray_to_binary_dec;

   logic       clk_in = 1'b0;
   logic       rst_n_in;
   logic       g_valid_in;
   logic       g_ready_out;
   logic [0:2] g_in;
   logic       b_valid_out;
   logic       b_ready_in;
   logic [0:2] b_out;
   logic       dir_out;
   logic       step_err_out;
   logic [7:0] err_cnt_out;

   int checks = 0;
   int failures = 0;

   // Behavioural model state
   int m_hist, m_prev, m_b, m_valid, m_dir, m_err, m_cnt;

   typedef struct {
      logic [0:2] g;
      logic [0:2] b;
   } vec_t;
   vec_t tbl [8];

   gray_to_binary_dec #(.WIDTH(3), .ERR_W(8)) dut (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .g_valid_in   (g_valid_in),
      .g_ready_out  (g_ready_out),
      .g_in         (g_in),
      .b_valid_out  (b_valid_out),
      .b_ready_in   (b_ready_in),
      .b_out        (b_out),
      .dir_out      (dir_out),
      .step_err_out (step_err_out),
      .err_cnt_out  (err_cnt_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [2:0] gray(input int n);
      return 3'(n ^ (n >> 1));
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hist = 0; m_prev = 0; m_b = 0; m_valid = 0; m_dir = 1; m_err = 0; m_cnt = 0;
   endtask

   // Decode by searching for the binary value whose Gray code matches.
   task automatic model_accept(input logic [0:2] g);
      int b, d;
      b = 0;
      for (int n = 0; n < 8; n++) if (gray(n) == 3'(g)) b = n;
      if (m_hist == 0) begin
         m_dir = 1; m_err = 0;
      end else begin
         d = (b - m_prev + 8) % 8;
         m_err = (d == 0 || d == 1 || d == 7) ? 0 : 1;
         if (d == 1) m_dir = 1;
         else if (d == 7) m_dir = 0;
         if (m_err && m_cnt < 255) m_cnt++;
      end
      m_hist = 1; m_prev = b; m_b = b; m_valid = 1;
   endtask

   task automatic check_out(input string tag);
      chk({tag, "_valid"}, int'(b_valid_out), m_valid);
      if (m_valid != 0) begin
         chk({tag, "_b"}, int'(b_out), m_b);
         chk({tag, "_err"}, int'(step_err_out), m_err);
      end else begin
         chk({tag, "_err"}, int'(step_err_out), 0);
      end
      chk({tag, "_dir"}, int'(dir_out), m_dir);
      chk({tag, "_cnt"}, int'(err_cnt_out), m_cnt);
   endtask

   task automatic do_reset();
      @(posedge clk_in); #1;
      rst_n_in = 1'b0; g_valid_in = 1'b0; b_ready_in = 1'b1;
      #2;
      rst_n_in = 1'b1;
      model_reset();
   endtask

   task automatic send(input string tag, input logic [0:2] g);
      g_in = g; g_valid_in = 1'b1; b_ready_in = 1'b1;
      model_accept(g);
      @(posedge clk_in); #1;
      g_valid_in = 1'b0;
      check_out(tag);
      $display("%s: g=%b b=%b dir=%0d err=%0d cnt=%0d", tag, g, b_out, dir_out, step_err_out, err_cnt_out);
   endtask

   initial begin
      tbl[0] = '{3'b000, 3'd0}; tbl[1] = '{3'b001, 3'd1};
      tbl[2] = '{3'b010, 3'd3}; tbl[3] = '{3'b011, 3'd2};
      tbl[4] = '{3'b100, 3'd7}; tbl[5] = '{3'b101, 3'd6};
      tbl[6] = '{3'b110, 3'd4}; tbl[7] = '{3'b111, 3'd5};

      rst_n_in = 1'b0; g_valid_in = 1'b0; g_in = '0; b_ready_in = 1'b1;
      model_reset();
      #12;
      chk("rst_valid", int'(b_valid_out), 0);
      chk("rst_b", int'(b_out), 0);
      chk("rst_dir", int'(dir_out), 1);
      chk("rst_err", int'(step_err_out), 0);
      chk("rst_cnt", int'(err_cnt_out), 0);
      rst_n_in = 1'b1;

      // 1. Exhaustive decode table
      for (int i = 0; i < 8; i++) begin
         send("decode", tbl[i].g);
         chk("decode_tbl", int'(b_out), int'(tbl[i].b));
      end

      // 2. Count up through wrap
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send("up", gray((6 + i) % 8));
         chk("up_b", int'(b_out), (6 + i) % 8);
         chk("up_dir", int'(dir_out), 1);
         chk("up_err", int'(step_err_out), 0);
         chk("up_cnt", int'(err_cnt_out), 0);
      end

      // 3. Count down 1,0,7 then jump to 4, then 5
      do_reset();
      send("down", gray(1));
      send("down", gray(0));
      chk("down_dir0", int'(dir_out), 0);
      send("down", gray(7));
      chk("down_dir7", int'(dir_out), 0);
      chk("down_err7", int'(step_err_out), 0);
      send("jump", 3'b110);
      chk("jump_err", int'(step_err_out), 1);
      chk("jump_cnt", int'(err_cnt_out), 1);
      send("resync", gray(5));
      chk("resync_err", int'(step_err_out), 0);
      chk("resync_dir", int'(dir_out), 1);

      // 4. Backpressure then back-to-back throughput
      do_reset();
      g_in = gray(2); g_valid_in = 1'b1; b_ready_in = 1'b0;
      model_accept(gray(2));
      @(posedge clk_in); #1;
      check_out("bp_first");
      g_in = gray(3);
      for (int i = 0; i < 4; i++) begin
         chk("bp_ready", int'(g_ready_out), 0);
         @(posedge clk_in); #1;
         chk("bp_hold_b", int'(b_out), 2);
         chk("bp_hold_valid", int'(b_valid_out), 1);
         $display("stall %0d: b=%b ready=%0d", i, b_out, g_ready_out);
      end
      b_ready_in = 1'b1;
      #1;
      chk("bp_release_ready", int'(g_ready_out), 1);
      model_accept(gray(3));
      @(posedge clk_in); #1;
      g_valid_in = 1'b0;
      check_out("bp_release");
      @(posedge clk_in); #1;
      chk("bp_no_dup", int'(b_valid_out), 0);
      for (int i = 0; i < 6; i++) begin
         g_in = gray((4 + i) % 8); g_valid_in = 1'b1; b_ready_in = 1'b1;
         chk("tput_ready", int'(g_ready_out), 1);
         model_accept(g_in);
         @(posedge clk_in); #1;
         check_out("tput");
         $display("tput %0d: b=%b", i, b_out);
      end
      g_valid_in = 1'b0;

      // 5. Async reset mid-stream with a pending output
      do_reset();
      send("pre_rst", gray(1));
      send("pre_rst_jump", gray(4));
      chk("pre_rst_cnt", int'(err_cnt_out), 1);
      b_ready_in = 1'b0;
      #1;
      rst_n_in = 1'b0;
      #1;
      chk("arst_valid", int'(b_valid_out), 0);
      chk("arst_b", int'(b_out), 0);
      chk("arst_dir", int'(dir_out), 1);
      chk("arst_err", int'(step_err_out), 0);
      chk("arst_cnt", int'(err_cnt_out), 0);
      model_reset();
      #2;
      rst_n_in = 1'b1;
      send("post_rst", gray(5));
      chk("post_rst_err", int'(step_err_out), 0);
      chk("post_rst_cnt", int'(err_cnt_out), 0);

      // 6. Saturation of the error counter
      do_reset();
      for (int i = 0; i < 300; i++) begin
         g_in = (i % 2 != 0) ? gray(4) : gray(0);
         g_valid_in = 1'b1; b_ready_in = 1'b1;
         model_accept(g_in);
         @(posedge clk_in); #1;
         if (i == 254) chk("sat_254", int'(err_cnt_out), 254);
         if (i == 255) chk("sat_255", int'(err_cnt_out), 255);
      end
      g_valid_in = 1'b0;
      chk("sat_end", int'(err_cnt_out), 255);
      check_out("sat");

      // Randomized comparison against the model
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         int k, tgt;
         g_valid_in = ($urandom % 4) != 0;
         b_ready_in = ($urandom % 4) != 0;
         k = $urandom % 8;
         if (k < 2) tgt = m_prev;
         else if (k < 4) tgt = (m_prev + 1) % 8;
         else if (k < 6) tgt = (m_prev + 7) % 8;
         else tgt = $urandom % 8;
         g_in = gray(tgt);
         #1;
         chk("rnd_ready", int'(g_ready_out), (m_valid == 0 || b_ready_in) ? 1 : 0);
         if (g_valid_in && (m_valid == 0 || b_ready_in)) model_accept(g_in);
         else if (m_valid != 0 && b_ready_in) m_valid = 0;
         @(posedge clk_in); #1;
         check_out("rnd");
      end
      g_valid_in = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
